// File: rtl/ctrl_pkg.sv
// Shared definitions for the lab processor control path: opcodes, FSM state
// encoding and write-bus source codes. Reused by the ALU and the bench.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_WAIT_ALU = 3'd4,
    ST_HALT     = 3'd5
  } state_t;

  localparam logic [3:0] OP_STORE  = 4'h8;
  localparam logic [3:0] OP_LOAD_A = 4'h9;
  localparam logic [3:0] OP_LOAD_B = 4'hA;
  localparam logic [3:0] OP_OUT    = 4'hB;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_SW_A = 2'd1;
  localparam logic [1:0] WSEL_SW_B = 2'd2;
  localparam logic [1:0] WSEL_REG  = 2'd3;

  localparam logic [1:0] DST_A = 2'd0;
  localparam logic [1:0] DST_B = 2'd1;

  localparam logic [7:0] RETIRED_MAX = 8'hFF;

  // Opcodes 0x0-0x7 are ALU operations: the top bit clear marks them.
  function automatic logic op_is_alu(input logic [3:0] opcode);
    return ~opcode[3];
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decode: turns the instruction register into
// ALU/HALT flags, register-load strobes and write-bus selects.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [7:0] ir,
  output logic       is_alu,
  output logic       is_halt,
  output logic       latch_a,
  output logic       latch_b,
  output logic       latch_o,
  output logic [1:0] wsel,
  output logic       rsel
);

  logic [3:0] opcode;
  logic [1:0] dst;
  logic       unused_ir_lsbs;

  assign opcode         = ir[7:4];
  assign dst            = ir[3:2];
  assign unused_ir_lsbs = ^ir[1:0];

  always_comb begin
    is_alu  = op_is_alu(opcode);
    is_halt = 1'b0;
    latch_a = 1'b0;
    latch_b = 1'b0;
    latch_o = 1'b0;
    wsel    = WSEL_ALU;
    rsel    = 1'b0;
    case (opcode)
      OP_STORE: begin
        wsel    = WSEL_ALU;
        latch_a = (dst == DST_A);
        latch_b = (dst == DST_B);
      end
      OP_LOAD_A: begin
        wsel    = WSEL_SW_A;
        latch_a = (dst == DST_A);
        latch_b = (dst == DST_B);
      end
      // SW B always lands in B regardless of the destination field.
      OP_LOAD_B: begin
        wsel    = WSEL_SW_B;
        latch_b = 1'b1;
      end
      OP_OUT: begin
        wsel    = WSEL_REG;
        latch_o = 1'b1;
        rsel    = (dst != DST_A);
      end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit lab processor: owns the PC,
// instruction register and retired count, and issues one-cycle strobes.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            step,
  input  logic            run,
  input  logic            clear,
  input  logic [1:0]      prog_sel,
  input  logic [7:0]      instr_in,
  input  logic            alu_done,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      rom_prog,
  output logic [7:0]      ir,
  output logic [3:0]      alu_sel,
  output logic            alu_start,
  output logic            latch_a,
  output logic            latch_b,
  output logic            latch_o,
  output logic [1:0]      wsel,
  output logic            rsel,
  output logic            halted,
  output logic [2:0]      state,
  output logic [7:0]      retired
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [7:0]      ir_q;
  logic [1:0]      rom_prog_q;
  logic [7:0]      retired_q;

  logic       dec_is_alu, dec_is_halt;
  logic       dec_latch_a, dec_latch_b, dec_latch_o;
  logic [1:0] dec_wsel;
  logic       dec_rsel;

  logic prog_change;
  logic retire;
  logic in_exec;

  instr_decode u_decode (
    .ir      (ir_q),
    .is_alu  (dec_is_alu),
    .is_halt (dec_is_halt),
    .latch_a (dec_latch_a),
    .latch_b (dec_latch_b),
    .latch_o (dec_latch_o),
    .wsel    (dec_wsel),
    .rsel    (dec_rsel)
  );

  // A program switch is only honoured while parked in IDLE or HALT.
  assign prog_change = (prog_sel != rom_prog_q) &&
                       ((state_q == ST_IDLE) || (state_q == ST_HALT));
  assign in_exec     = (state_q == ST_EXEC);
  assign retire      = !clear &&
                       ((in_exec && !dec_is_alu && !dec_is_halt) ||
                        ((state_q == ST_WAIT_ALU) && alu_done));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear || prog_change) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (step || run) state_d = ST_FETCH;
        ST_FETCH:    state_d = ST_DECODE;
        ST_DECODE:   state_d = ST_EXEC;
        ST_EXEC: begin
          if (dec_is_alu)       state_d = ST_WAIT_ALU;
          else if (dec_is_halt) state_d = ST_HALT;
          else                  state_d = ST_IDLE;
        end
        ST_WAIT_ALU: if (alu_done) state_d = ST_IDLE;
        ST_HALT:     state_d = ST_HALT;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= '0;
      ir_q       <= '0;
      rom_prog_q <= '0;
      retired_q  <= '0;
    end else if (clear) begin
      pc_q <= '0;
    end else if (prog_change) begin
      pc_q       <= '0;
      retired_q  <= '0;
      rom_prog_q <= prog_sel;
    end else begin
      if (state_q == ST_FETCH) begin
        ir_q <= instr_in;
        pc_q <= pc_q + PC_W'(1);
      end
      if (retire && (retired_q != RETIRED_MAX)) retired_q <= retired_q + 8'd1;
    end
  end

  always_comb begin
    alu_start = in_exec && dec_is_alu;
    latch_a   = in_exec && dec_latch_a;
    latch_b   = in_exec && dec_latch_b;
    latch_o   = in_exec && dec_latch_o;
    wsel      = in_exec ? dec_wsel : WSEL_ALU;
    rsel      = in_exec && dec_rsel;
    alu_sel   = 4'd0;
    if (dec_is_alu && ((state_q == ST_DECODE) || in_exec || (state_q == ST_WAIT_ALU)))
      alu_sel = ir_q[7:4];
    halted    = (state_q == ST_HALT);
    state     = state_q;
    pc        = pc_q;
    ir        = ir_q;
    rom_prog  = rom_prog_q;
    retired   = retired_q;
  end

endmodule
